// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, reads the combinational ROM, buffers {pc, instr} pairs for decode.
// Latency: an entry is on out_* one cycle after its address is driven; one per cycle when drained.
// Backpressure: out_ready=0 fills the buffer, then fetch stalls with the PC held.
module fetch_stage #(
    parameter int                XLEN       = 32,
    parameter int                ADDRLEN    = 16,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDRLEN-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               halted
);

    localparam int              PW    = $clog2(FIFO_DEPTH);
    localparam int              CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] ECALL = 32'h0000_0073;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] buf_pc    [FIFO_DEPTH];
    logic [XLEN-1:0] buf_instr [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            push;
    logic            pop;
    logic            redirect_pc_unused;

    // Word alignment is forced, so the low target bits carry no information.
    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign imem_addr = pc[ADDRLEN-1:0];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = !redirect_valid && !halted && ((count < CW'(FIFO_DEPTH)) || pop);

    assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[XLEN-1:2], 2'b00};
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            halted <= 1'b0;
        end else begin
            count <= count_nxt;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
                if (imem_data == ECALL) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    // Storage is left unreset; out_* masking keeps stale contents invisible.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected PCs checked on every handshake.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    logic [31:0] rom [64];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr[7:2]];

    fetch_stage #(
        .XLEN(32), .ADDRLEN(16), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    task automatic expect_from(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // One clock: score any handshake on the falling edge, then settle after the rising edge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_instr", out_instr, rom[e[7:2]]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | 32'(i);
        rom[0]  = 32'h0000_02B3;
        rom[1]  = 32'h00B0_0313;
        rom[11] = 32'h00A0_0513;
        rom[12] = 32'h0000_0073;
        rom[13] = 32'hFF41_0113;

        rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        tick();
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_instr",  out_instr, 32'd0);
        chk("rst_pc",     out_pc, 32'd0);
        chk("rst_addr",   {16'd0, imem_addr}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Streaming with decode always ready
        rst_n = 1'b1; out_ready = 1'b1;
        expect_from(32'h0, 16);
        tick();
        chk("s1_pc0",    out_pc, 32'h0);
        chk("s1_instr0", out_instr, 32'h0000_02B3);
        tick();
        chk("s1_pc1",    out_pc, 32'h4);
        chk("s1_instr1", out_instr, 32'h00B0_0313);
        tick();
        chk("s1_pc2",    out_pc, 32'h8);
        tick();
        tick();
        chk("s1_pc4",    out_pc, 32'h10);

        // Stall: buffer fills, PC holds, head stable
        rst_n = 1'b0; out_ready = 1'b0;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        expect_from(32'h0, 16);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s2_valid", {31'd0, out_valid}, 32'd1);
            chk("s2_pc",    out_pc, 32'h0);
            chk("s2_instr", out_instr, 32'h0000_02B3);
        end
        chk("s2_addr", {16'd0, imem_addr}, 32'h8);

        // Redirect with two entries buffered, unaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h2E;
        tick();
        exp_q.delete();
        expect_from(32'h2C, 16);
        redirect_valid = 1'b0;
        chk("s3_valid", {31'd0, out_valid}, 32'd0);
        chk("s3_addr",  {16'd0, imem_addr}, 32'h2C);
        out_ready = 1'b1;
        tick();
        chk("s3_pc",    out_pc, 32'h2C);
        chk("s3_instr", out_instr, 32'h00A0_0513);

        // ECALL at 0x30 halts fetch
        tick();
        chk("s4_pc",     out_pc, 32'h30);
        chk("s4_instr",  out_instr, 32'h0000_0073);
        chk("s4_halted", {31'd0, halted}, 32'd1);
        tick();
        chk("s4_drain",  {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        chk("s4_hold",   {31'd0, out_valid}, 32'd0);
        chk("s4_addr",   {16'd0, imem_addr}, 32'h34);
        chk("s4_halt2",  {31'd0, halted}, 32'd1);
        exp_q.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h34;
        tick();
        redirect_valid = 1'b0;
        expect_from(32'h34, 16);
        chk("s4_unhalt", {31'd0, halted}, 32'd0);
        out_ready = 1'b0;
        tick();
        chk("s4_rpc",    out_pc, 32'h34);
        chk("s4_rinstr", out_instr, 32'hFF41_0113);
        tick();

        // Reset mid-stream with two entries queued
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        chk("s5_valid", {31'd0, out_valid}, 32'd0);
        chk("s5_addr",  {16'd0, imem_addr}, 32'h0);
        chk("s5_pc",    out_pc, 32'h0);
        rst_n = 1'b1;
        expect_from(32'h0, 20);

        // Full buffer with simultaneous pop and push
        tick();
        tick();
        chk("s6_full_addr", {16'd0, imem_addr}, 32'h8);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s6_valid", {31'd0, out_valid}, 32'd1);
            chk("s6_addr",  {16'd0, imem_addr}, 32'h8 + 32'(4 * (i + 1)));
        end
        out_ready = 1'b0;
        tick();
        chk("s6_still_full", {16'd0, imem_addr}, 32'h30);
        chk("s6_head",       out_pc, 32'h28);

        // Back-to-back redirects: the last one wins
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        exp_q.delete();
        redirect_pc = 32'h1F;
        tick();
        redirect_valid = 1'b0;
        expect_from(32'h1C, 8);
        chk("s7_addr", {16'd0, imem_addr}, 32'h1C);
        tick();
        chk("s7_pc", out_pc, 32'h1C);
        tick();
        tick();
        chk("s7_pc2", out_pc, 32'h24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
